serial_paralelo_active: RTL and testbench

Receive-side serial-to-parallel converter with comma alignment for the physical-layer lane. It runs in the `clk_32f` domain and samples one bit per cycle from the serial link. It hunts for the 0xBC comma to find byte boundaries and asserts `active` after a run of consecutive commas. It then delivers payload bytes with `valid_out`, and `active` is the signal the recirculation stage uses to choose between forwarding data and looping it back to the tester.

---
 rtl/serial_paralelo_active.sv | 118 +++++++++++
 tb/tb_serial_paralelo_active.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/serial_paralelo_active.sv
// Receive-side serial-to-parallel converter with 0xBC comma alignment.
// Hunts for the comma, locks after BC_NEEDED consecutive aligned commas, then delivers payload bytes.
module serial_paralelo_active #(
  parameter logic [7:0]  COMMA     = 8'hBC,
  parameter int unsigned BC_NEEDED = 4
) (
  input  logic       clk_32f,
  input  logic       reset_L,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active,
  output logic       byte_strobe
);

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_ALIGNED,
    ST_ACTIVE
  } state_t;

  localparam logic [3:0] BC_TARGET = 4'(BC_NEEDED);

  state_t     state_q, state_d;
  logic [7:0] sr_q, sr_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] bc_cnt_q, bc_cnt_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       strobe_q, strobe_d;

  logic [7:0] nsr;
  logic       byte_done;
  logic       is_comma;
  logic [3:0] bc_inc;

  assign nsr       = {sr_q[6:0], data_in};
  assign byte_done = (bit_cnt_q == 3'd7);
  assign is_comma  = (nsr == COMMA);
  assign bc_inc    = bc_cnt_q + 4'd1;

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    sr_d      = nsr;
    bit_cnt_d = bit_cnt_q + 3'd1;
    bc_cnt_d  = bc_cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    strobe_d  = 1'b0;

    case (state_q)
      ST_HUNT: begin
        // Sliding compare; a match marks the end of a byte, so the next bit starts a new one.
        bit_cnt_d = 3'd0;
        if (is_comma) begin
          state_d  = ST_ALIGNED;
          bc_cnt_d = 4'd1;
        end
      end

      ST_ALIGNED: begin
        if (byte_done) begin
          if (is_comma) begin
            bc_cnt_d = bc_inc;
            if (bc_inc == BC_TARGET) state_d = ST_ACTIVE;
          end else begin
            state_d  = ST_HUNT;
            bc_cnt_d = 4'd0;
          end
        end
      end

      ST_ACTIVE: begin
        if (byte_done) begin
          strobe_d = 1'b1;
          // Commas are idles: drop valid but keep the last payload byte on data_out.
          if (is_comma) begin
            valid_d = 1'b0;
          end else begin
            data_d  = nsr;
            valid_d = 1'b1;
          end
        end
      end

      default: state_d = ST_HUNT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      state_q   <= ST_HUNT;
      sr_q      <= 8'h00;
      bit_cnt_q <= 3'd0;
      bc_cnt_q  <= 4'd0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      strobe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      bc_cnt_q  <= bc_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      strobe_q  <= strobe_d;
    end
  end

  assign data_out    = data_q;
  assign valid_out   = valid_q;
  assign byte_strobe = strobe_q;
  // ACTIVE is only left through reset, so the state register itself provides the sticky flag.
  assign active      = (state_q == ST_ACTIVE);

endmodule

// File: tb/tb_serial_paralelo_active.sv
// Self-checking bench for serial_paralelo_active: table-driven byte vectors plus hand-written
// sequences for async reset, misaligned lock, broken comma run and BC_NEEDED=2.
module tb_serial_paralelo_active;

  logic       clk_32f;
  logic       reset_L;
  logic       data_in;
  logic [7:0] data_out, data_out2;
  logic       valid_out, valid_out2;
  logic       active, active2;
  logic       byte_strobe, byte_strobe2;

  int checks   = 0;
  int failures = 0;

  serial_paralelo_active #(.COMMA(8'hBC), .BC_NEEDED(4)) dut (
    .clk_32f    (clk_32f),
    .reset_L    (reset_L),
    .data_in    (data_in),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .active     (active),
    .byte_strobe(byte_strobe)
  );

  serial_paralelo_active #(.COMMA(8'hBC), .BC_NEEDED(2)) dut2 (
    .clk_32f    (clk_32f),
    .reset_L    (reset_L),
    .data_in    (data_in),
    .data_out   (data_out2),
    .valid_out  (valid_out2),
    .active     (active2),
    .byte_strobe(byte_strobe2)
  );

  initial clk_32f = 1'b0;
  always #5 clk_32f = ~clk_32f;

  typedef struct {
    logic [7:0] byte_in;
    logic       exp_active;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_strobe;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // One bit per rising edge; outputs are sampled 1 time unit after the edge.
  task automatic tick(input logic b);
    data_in = b;
    @(posedge clk_32f);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) tick(b[i]);
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    repeat (2) @(posedge clk_32f);
    #1;
    reset_L = 1'b1;
  endtask

  logic       prev_valid;
  logic [7:0] prev_data;

  initial begin
    data_in = 1'b0;
    reset_L = 1'b0;
    #1;
    check("reset_data_out", 32'(data_out), 32'h00);
    check("reset_valid", 32'(valid_out), 32'h0);
    check("reset_active", 32'(active), 32'h0);
    check("reset_strobe", 32'(byte_strobe), 32'h0);
    repeat (2) @(posedge clk_32f);
    #1;
    reset_L = 1'b1;

    // Aligned lock (edge 32), first payload at edge 40, then idles among data.
    vecs[0] = '{8'hBC, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{8'hBC, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[2] = '{8'hBC, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[3] = '{8'hBC, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1};
    vecs[5] = '{8'h12, 1'b1, 1'b1, 8'h12, 1'b1};
    vecs[6] = '{8'hBC, 1'b1, 1'b0, 8'h12, 1'b1};
    vecs[7] = '{8'h34, 1'b1, 1'b1, 8'h34, 1'b1};

    prev_valid = 1'b0;
    prev_data  = 8'h00;
    for (int i = 0; i < 8; i++) begin
      tick(vecs[i].byte_in[7]);
      check($sformatf("v%0d_strobe_low_mid", i), 32'(byte_strobe), 32'h0);
      check($sformatf("v%0d_valid_hold", i), 32'(valid_out), 32'(prev_valid));
      check($sformatf("v%0d_data_hold", i), 32'(data_out), 32'(prev_data));
      for (int b = 6; b >= 0; b--) tick(vecs[i].byte_in[b]);
      check($sformatf("v%0d_active", i), 32'(active), 32'(vecs[i].exp_active));
      check($sformatf("v%0d_valid", i), 32'(valid_out), 32'(vecs[i].exp_valid));
      check($sformatf("v%0d_data", i), 32'(data_out), 32'(vecs[i].exp_data));
      check($sformatf("v%0d_strobe", i), 32'(byte_strobe), 32'(vecs[i].exp_strobe));
      prev_valid = vecs[i].exp_valid;
      prev_data  = vecs[i].exp_data;
    end

    // Async reset mid-byte while ACTIVE with valid_out=1: outputs clear before any edge.
    tick(1'b1);
    tick(1'b0);
    #2;
    reset_L = 1'b0;
    #1;
    check("async_rst_data", 32'(data_out), 32'h00);
    check("async_rst_valid", 32'(valid_out), 32'h0);
    check("async_rst_active", 32'(active), 32'h0);
    check("async_rst_strobe", 32'(byte_strobe), 32'h0);
    repeat (3) @(posedge clk_32f);
    #1;
    check("rst_held_active", 32'(active), 32'h0);
    reset_L = 1'b1;

    // Misaligned lock: three stray bits, comma found at edge 11, active after edge 35.
    tick(1'b1);
    tick(1'b0);
    tick(1'b1);
    for (int i = 0; i < 3; i++) send_byte(8'hBC);
    check("mis_active_e27", 32'(active), 32'h0);
    send_byte(8'hBC);
    check("mis_active_e35", 32'(active), 32'h1);
    check("mis_strobe_e35", 32'(byte_strobe), 32'h0);
    check("mis_valid_e35", 32'(valid_out), 32'h0);
    send_byte(8'h3C);
    check("mis_data_e43", 32'(data_out), 32'h3C);
    check("mis_valid_e43", 32'(valid_out), 32'h1);
    check("mis_strobe_e43", 32'(byte_strobe), 32'h1);

    // Broken run: the 0x00 byte clears the comma count, so active waits for edge 64.
    do_reset();
    send_byte(8'hBC);
    send_byte(8'hBC);
    send_byte(8'hBC);
    send_byte(8'h00);
    for (int i = 0; i < 3; i++) begin
      send_byte(8'hBC);
      check($sformatf("broken_active_bc%0d", i), 32'(active), 32'h0);
    end
    send_byte(8'hBC);
    check("broken_active_e64", 32'(active), 32'h1);
    check("broken_valid_e64", 32'(valid_out), 32'h0);

    // BC_NEEDED=2 instance: active after edge 16, payload after edge 24.
    do_reset();
    send_byte(8'hBC);
    check("p2_active_e8", 32'(active2), 32'h0);
    send_byte(8'hBC);
    check("p2_active_e16", 32'(active2), 32'h1);
    check("p4_active_e16", 32'(active), 32'h0);
    send_byte(8'h55);
    check("p2_data_e24", 32'(data_out2), 32'h55);
    check("p2_valid_e24", 32'(valid_out2), 32'h1);
    check("p2_strobe_e24", 32'(byte_strobe2), 32'h1);
    tick(1'b0);
    check("p2_strobe_drop", 32'(byte_strobe2), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Backstop so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
